// File: rtl/tdm_pkg.sv
// Constants and types shared by the TDM link: slot count, slot index and FSM state.
// The transmit-side mux imports the same package so both ends agree on framing.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

endpackage

// File: rtl/tdm_slot_deser.sv
// Per-slot deserialiser: assembles W serial bits (MSB first) into a word and
// counts bits so the parent knows when the current shift completes the word.
module tdm_slot_deser #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] word,
  output logic         word_done
);

  localparam int            BW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;

  // word_done means "a shift this cycle completes the word"; it does not depend
  // on shift_en, so the parent can gate it without forming a combinational loop.
  assign word_done = (bcnt_q == LAST_BIT);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    bcnt_d = bcnt_q;
    if (clear) begin
      bcnt_d = '0;
    end else if (shift_en) begin
      bcnt_d = word_done ? '0 : bcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values regardless of block order.
    if (rst) bcnt_q <= '0;
    else     bcnt_q <= bcnt_d;
  end

  // The stored bits plus the live din form the word, so the final bit is
  // available in the same cycle it arrives.
  if (W > 1) begin : g_shift
    logic [W-2:0] sh_q, sh_d;

    assign word = {sh_q, din};

    always_comb begin
      sh_d = sh_q;
      if (clear)         sh_d = '0;
      else if (shift_en) sh_d = word[W-2:0];
    end

    always_ff @(posedge clk) begin
      if (rst) sh_q <= '0;
      else     sh_q <= sh_d;
    end
  end else begin : g_single
    assign word = din;
  end

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link: frames on sync, deserialises four W-bit slots
// into shadow registers and publishes them on dout atomically with a valid pulse.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   sync,
  input  logic                   din,
  output logic [NUM_SLOTS*W-1:0] dout,
  output logic                   valid,
  output logic                   frame_err,
  output logic                   busy,
  output logic [SLOT_W-1:0]      slot
);

  state_t                 state_q, state_d;
  slot_t                  slot_q, slot_d;
  logic [W-1:0]           shadow_q [NUM_SLOTS];
  logic [W-1:0]           shadow_d [NUM_SLOTS];
  logic [NUM_SLOTS*W-1:0] dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic         deser_clear;
  logic         shift_en;
  logic [W-1:0] word;
  logic         word_done;

  tdm_slot_deser #(.W(W)) u_deser (
    .clk       (clk),
    .rst       (rst),
    .clear     (deser_clear),
    .shift_en  (shift_en),
    .din       (din),
    .word      (word),
    .word_done (word_done)
  );

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    shadow_d    = shadow_q;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    deser_clear = 1'b0;
    shift_en    = 1'b0;

    if (en) begin
      case (state_q)
        IDLE: begin
          if (sync) begin
            state_d     = RECV;
            slot_d      = '0;
            deser_clear = 1'b1;
          end
        end
        RECV: begin
          if (sync) begin
            // Early sync restarts the frame; stale shadow words are overwritten before reuse.
            err_d       = 1'b1;
            slot_d      = '0;
            deser_clear = 1'b1;
          end else begin
            shift_en = 1'b1;
            if (word_done) begin
              shadow_d[slot_q] = word;
              if (slot_q == LAST_SLOT) begin
                for (int i = 0; i < NUM_SLOTS; i++) dout_d[W*i +: W] = shadow_d[i];
                valid_d = 1'b1;
                state_d = IDLE;
                slot_d  = '0;
              end else begin
                slot_d = slot_q + 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      // NOTE: the shadow array is small register storage, so it is reset explicitly rather than left as uninitialised memory.
      for (int i = 0; i < NUM_SLOTS; i++) shadow_q[i] <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q == RECV);
  assign slot      = slot_q;

endmodule
